// File: rtl/cwru_transceiver_tx_pkg.sv
// Shared types and constants for the keypad UART transmitter.
// The PARITY_EN macro enables the parity state value used by the top module.
package cwru_tx_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_START  = 3'd1;
  localparam state_t ST_DATA   = 3'd2;
  localparam state_t ST_PARITY = 3'd3;
  localparam state_t ST_STOP   = 3'd4;

  localparam logic [7:0] ASCII_BASE = 8'h30;

  // Active-low {g,f,e,d,c,b,a}; entries 0..3 are the digits, entry 4 is blank.
  localparam logic [4:0][6:0] SEG_TABLE = {7'h7F, 7'h30, 7'h24, 7'h79, 7'h40};
  localparam logic [2:0]      SEG_BLANK_IDX = 3'd4;

  function automatic logic [1:0] lowest_index(input logic [3:0] ev);
    if (ev[0]) return 2'd0;
    if (ev[1]) return 2'd1;
    if (ev[2]) return 2'd2;
    return 2'd3;
  endfunction

endpackage

// File: rtl/cwru_transceiver_tx_key_conditioner.sv
// One pushbutton: 2-flop synchronizer, down-counter debounce, one-cycle press pulse.
// The key is active-low; the debounced level resets to released (1).
module key_conditioner #(
  parameter int DEBOUNCE_CYCLES = 5000
) (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] RELOAD = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      level <= 1'b1;
      cnt   <= RELOAD;
      press <= 1'b0;
    end else begin
      sync1 <= key;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == level) begin
        cnt <= RELOAD;
      end else if (cnt == '0) begin
        // Nth consecutive differing sample: accept it; only 1->0 is a press.
        level <= sync2;
        cnt   <= RELOAD;
        press <= level;
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/cwru_transceiver_tx.sv
// Keypad-driven 8N1 UART transmitter: press arbitration, one-deep pending slot, TX FSM, HEX0.
// Define PARITY_EN to insert an even-parity bit between data and stop.
//
// state  | meaning
// IDLE   | line high, waiting for a press event
// START  | start bit (0)
// DATA   | 8 data bits, LSB first
// PARITY | even parity over data (PARITY_EN only)
// STOP   | stop bit (1); chains straight into START when a key is pending
module cwru_transceiver_tx
  import cwru_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT    = 5208,
  parameter int DEBOUNCE_CYCLES = 5000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [3:0]  KEY,
  output logic [35:0] GPIO_1,
  output logic [6:0]  HEX0
);

  localparam int TW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [TW-1:0] BIT_RELOAD = TW'(CLKS_PER_BIT - 1);

  logic [3:0]    press;
  state_t        state;
  logic [TW-1:0] timer;
  logic [2:0]    bit_idx;
  logic [7:0]    data;
  logic          pend_valid;
  logic [1:0]    pend_idx;
  logic [6:0]    hex;

  logic          ev_any;
  logic [1:0]    ev_idx;
  logic          bit_done;
  logic          launch;
  logic [1:0]    launch_idx;
  logic          take_pend;
  logic          store_pend;
  logic          tx;
  logic          busy;

  for (genvar i = 0; i < 4; i++) begin : g_key
    key_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key (
      .clk  (CLK),
      .rst  (RST),
      .key  (KEY[i]),
      .press(press[i])
    );
  end

  assign ev_any   = |press;
  assign ev_idx   = lowest_index(press);
  assign bit_done = (timer == '0);
  assign busy     = (state != ST_IDLE);

  always_comb begin
    launch     = 1'b0;
    launch_idx = ev_idx;
    take_pend  = 1'b0;
    if (state == ST_IDLE) begin
      launch = ev_any;
    end else if (state == ST_STOP && bit_done) begin
      if (pend_valid) begin
        launch     = 1'b1;
        launch_idx = pend_idx;
        take_pend  = 1'b1;
      end else begin
        // An event landing on the last stop cycle goes out directly rather than parking.
        launch = ev_any;
      end
    end
    store_pend = ev_any && busy && !pend_valid && !launch;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= ST_IDLE;
      timer      <= BIT_RELOAD;
      bit_idx    <= 3'd0;
      data       <= ASCII_BASE;
      pend_valid <= 1'b0;
      pend_idx   <= 2'd0;
      hex        <= SEG_TABLE[SEG_BLANK_IDX];
    end else begin
      if (take_pend) begin
        pend_valid <= 1'b0;
      end else if (store_pend) begin
        pend_valid <= 1'b1;
        pend_idx   <= ev_idx;
      end

      if (launch) begin
        state   <= ST_START;
        timer   <= BIT_RELOAD;
        bit_idx <= 3'd0;
        data    <= ASCII_BASE + {6'd0, launch_idx};
        hex     <= SEG_TABLE[{1'b0, launch_idx}];
      end else if (busy) begin
        if (!bit_done) begin
          timer <= timer - 1'b1;
        end else begin
          timer <= BIT_RELOAD;
          case (state)
            ST_START: state <= ST_DATA;
            ST_DATA: begin
              if (bit_idx == 3'd7) begin
`ifdef PARITY_EN
                state <= ST_PARITY;
`else
                state <= ST_STOP;
`endif
              end else begin
                bit_idx <= bit_idx + 3'd1;
              end
            end
`ifdef PARITY_EN
            ST_PARITY: state <= ST_STOP;
`endif
            default: state <= ST_IDLE;
          endcase
        end
      end
    end
  end

  always_comb begin
    tx = 1'b1;
    case (state)
      ST_START: tx = 1'b0;
      ST_DATA:  tx = data[bit_idx];
`ifdef PARITY_EN
      ST_PARITY: tx = ^data;
`endif
      default:  tx = 1'b1;
    endcase
  end

  assign GPIO_1 = {34'd0, busy, tx};
  assign HEX0   = hex;

endmodule

// File: tb/tb_cwru_transceiver_tx.sv
// Bench for cwru_transceiver_tx: random key stimulus, a UART receiver monitor and
// an expected-frame list built from the press/arbitration/queueing rules.
module tb_cwru_transceiver_tx;

  localparam int CPB = 16;
  localparam int DEB = 10;
`ifdef PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam int FRAME = FB * CPB;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  key;
  logic [35:0] gpio;
  logic [6:0]  hex;

  int     errors = 0;
  int     checks = 0;
  longint cyc = 0;

  logic [6:0] seg_ref [4] = '{7'h40, 7'h79, 7'h24, 7'h30};

  logic [7:0] byte_q [$];
  logic [6:0] hex_q  [$];
  longint     start_q[$];
  bit         ok_q   [$];
  int         exp_q  [$];

  cwru_transceiver_tx #(.CLKS_PER_BIT(CPB), .DEBOUNCE_CYCLES(DEB)) dut (
    .CLK   (clk),
    .RST   (rst),
    .KEY   (key),
    .GPIO_1(gpio),
    .HEX0  (hex)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Receiver: a frame begins on the first cycle TX is seen low; every bit must hold
  // its level for exactly CPB cycles. A frame during which busy drops is discarded.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (gpio[0] === 1'b0) begin
        longint           t0;
        logic [6:0]       h0;
        bit               aborted;
        bit               shape_ok;
        logic [FRAME-1:0] s;
        logic [7:0]       b;
        t0 = cyc;
        h0 = hex;
        aborted = (gpio[1] !== 1'b1);
        shape_ok = 1'b1;
        s[0] = gpio[0];
        for (int i = 1; i < FRAME && !aborted; i++) begin
          @(negedge clk);
          if (gpio[1] !== 1'b1) aborted = 1'b1;
          s[i] = gpio[0];
        end
        if (!aborted) begin
          for (int k = 0; k < FB; k++)
            for (int j = 1; j < CPB; j++)
              if (s[k*CPB+j] !== s[k*CPB]) shape_ok = 1'b0;
          if (s[0] !== 1'b0 || s[(FB-1)*CPB] !== 1'b1) shape_ok = 1'b0;
          for (int k = 0; k < 8; k++) b[k] = s[(k+1)*CPB];
`ifdef PARITY_EN
          if (s[9*CPB] !== ^b) shape_ok = 1'b0;
`endif
          byte_q.push_back(b);
          hex_q.push_back(h0);
          start_q.push_back(t0);
          ok_q.push_back(shape_ok);
        end
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic press(input logic [3:0] pat, input int hold, output longint tp);
    @(negedge clk);
    key = pat;
    tp = cyc;
    repeat (hold) @(negedge clk);
    key = 4'hF;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_q();
    byte_q.delete();
    hex_q.delete();
    start_q.delete();
    ok_q.delete();
    exp_q.delete();
  endtask

  task automatic check_frames(input string tag);
    check({tag, ":count"}, 64'(byte_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < byte_q.size(); i++) begin
      check({tag, ":data"}, 64'(byte_q[i]), 64'(8'h30 + exp_q[i]));
      check({tag, ":hex"}, 64'(hex_q[i]), 64'(seg_ref[exp_q[i]]));
      check({tag, ":shape"}, 64'(ok_q[i]), 64'(1));
    end
    check({tag, ":idle_busy"}, 64'(gpio[1]), 64'(0));
    check({tag, ":idle_tx"}, 64'(gpio[0]), 64'(1));
  endtask

  function automatic int lowest_pressed(input logic [3:0] pat);
    int w;
    w = -1;
    for (int i = 3; i >= 0; i--) if (!pat[i]) w = i;
    return w;
  endfunction

  initial begin : main
    int          a, b, c, hold;
    logic [3:0]  pat;
    longint      tp, lat;

    rst = 1'b1;
    key = 4'hF;
    repeat (3) @(negedge clk);
    check("reset_gpio", 64'(gpio), 64'h1);
    check("reset_hex", 64'(hex), 64'h7F);
    check("reset_busy", 64'(gpio[1]), 64'(0));
    rst = 1'b0;
    idle(DEB + 5);

    // single key, latency and frame content
    clear_q();
    a = $urandom_range(0, 3);
    hold = DEB + $urandom_range(5, 30);
    pat = 4'hF;
    pat[a] = 1'b0;
    press(pat, hold, tp);
    exp_q.push_back(a);
    idle(FRAME + 3 * DEB + 20);
    check_frames("single");
    if (start_q.size() > 0) begin
      lat = start_q[0] - tp;
      check("single:latency", (lat >= DEB + 1 && lat <= DEB + 3) ? 64'(DEB + 2) : 64'(lat),
            64'(DEB + 2));
    end else begin
      check("single:latency_seen", 64'(0), 64'(1));
    end
    check("single:hex_hold", 64'(hex), 64'(seg_ref[a]));

    // simultaneous keys: lowest index only
    for (int r = 0; r < 2; r++) begin
      clear_q();
      a = $urandom_range(0, 3);
      b = (a + 1 + $urandom_range(0, 2)) % 4;
      pat = 4'($urandom_range(0, 15));
      pat[a] = 1'b0;
      pat[b] = 1'b0;
      press(pat, DEB + 8, tp);
      exp_q.push_back(lowest_pressed(pat));
      idle(2 * FRAME + 3 * DEB);
      check_frames("multi");
    end

    // press during a frame goes back-to-back
    clear_q();
    a = $urandom_range(0, 3);
    b = $urandom_range(0, 3);
    pat = 4'hF; pat[a] = 1'b0;
    press(pat, DEB + 8, tp);
    idle(30);
    pat = 4'hF; pat[b] = 1'b0;
    press(pat, DEB + 8, tp);
    exp_q.push_back(a);
    exp_q.push_back(b);
    idle(2 * FRAME + 50);
    check_frames("b2b");
    if (start_q.size() == 2)
      check("b2b:gap", 64'(start_q[1] - start_q[0]), 64'(FRAME));
    check("b2b:hex_last", 64'(hex), 64'(seg_ref[b]));

    // all keys held, then key 1 and mid-frame keys 2+3
    clear_q();
    press(4'b0000, DEB + 8, tp);
    exp_q.push_back(0);
    idle(FRAME + 40);
    check_frames("all");
    clear_q();
    press(4'b1101, DEB + 8, tp);
    idle(30);
    press(4'b0011, DEB + 8, tp);
    exp_q.push_back(1);
    exp_q.push_back(2);
    idle(2 * FRAME + 50);
    check_frames("pair");

    // pending slot already full: third press discarded
    clear_q();
    a = $urandom_range(0, 3);
    b = $urandom_range(0, 3);
    c = $urandom_range(0, 3);
    pat = 4'hF; pat[a] = 1'b0;
    press(pat, DEB + 8, tp);
    idle(20);
    pat = 4'hF; pat[b] = 1'b0;
    press(pat, DEB + 8, tp);
    idle(10);
    pat = 4'hF; pat[c] = 1'b0;
    press(pat, DEB + 8, tp);
    exp_q.push_back(a);
    exp_q.push_back(b);
    idle(3 * FRAME + 50);
    check_frames("full");

    // glitch shorter than debounce
    clear_q();
    press(4'b1110, $urandom_range(1, DEB - 2), tp);
    idle(FRAME + 3 * DEB);
    check_frames("glitch");

    // reset mid-frame with a pending key
    clear_q();
    a = $urandom_range(0, 3);
    b = $urandom_range(0, 3);
    pat = 4'hF; pat[a] = 1'b0;
    press(pat, DEB + 8, tp);
    idle(10);
    pat = 4'hF; pat[b] = 1'b0;
    press(pat, DEB + 5, tp);
    idle(40);
    check("rst:pre_busy", 64'(gpio[1]), 64'(1));
    rst = 1'b1;
    @(negedge clk);
    check("rst:tx", 64'(gpio[0]), 64'(1));
    check("rst:busy", 64'(gpio[1]), 64'(0));
    check("rst:hex", 64'(hex), 64'h7F);
    rst = 1'b0;
    idle(2 * FRAME + 3 * DEB);
    check_frames("rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
